// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: fetch FSM state encoding and the opcodes
// that the fetch sequencer reacts to.
package lc3_pkg;

    typedef enum logic [2:0] {
        ST_HALTED = 3'd0,
        ST_FETCH1 = 3'd1,
        ST_FETCH2 = 3'd2,
        ST_FETCH3 = 3'd3,
        ST_FETCH4 = 3'd4,
        ST_DECODE = 3'd5,
        ST_PAUSE_A = 3'd6,
        ST_PAUSE_B = 3'd7
    } fetch_state_e;

    localparam logic [3:0] OP_PAUSE = 4'b1101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

endpackage

// File: rtl/fetch_control.sv
// LC-3 instruction fetch sequencer: Moore FSM driving datapath load enables,
// bus gates and memory strobes, with a programmable memory wait in FETCH2.
module fetch_control
    import lc3_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       cont,
    input  logic [3:0] opcode,
    output logic       ld_pc,
    output logic       ld_ir,
    output logic       ld_mar,
    output logic       ld_mdr,
    output logic       gate_pc,
    output logic       gate_mdr,
    output logic       gate_alu,
    output logic       gate_marmux,
    output logic       mio_en,
    output logic       mem_oe_n,
    output logic       mem_we_n,
    output logic       halted,
    output logic       paused
);

    // Counter value of the final FETCH2 cycle; MEM_WAIT is limited to 1..7.
    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    fetch_state_e state_r;
    fetch_state_e next_state_s;
    logic [2:0]   wait_cnt_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HALTED;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Memory wait counter: zero on entry to FETCH2, counts while there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= 3'd0;
        end else if (state_r == ST_FETCH2) begin
            wait_cnt_r <= wait_cnt_r + 3'd1;
        end else begin
            wait_cnt_r <= 3'd0;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_HALTED: begin
                if (run) begin
                    next_state_s = ST_FETCH1;
                end else begin
                    next_state_s = ST_HALTED;
                end
            end
            ST_FETCH1: next_state_s = ST_FETCH2;
            ST_FETCH2: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = ST_FETCH3;
                end else begin
                    next_state_s = ST_FETCH2;
                end
            end
            ST_FETCH3: next_state_s = ST_FETCH4;
            ST_FETCH4: next_state_s = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OP_PAUSE) begin
                    next_state_s = ST_PAUSE_A;
                end else if (opcode == OP_HALT) begin
                    next_state_s = ST_HALTED;
                end else begin
                    next_state_s = ST_FETCH1;
                end
            end
            // Continue must be released before the next instruction starts,
            // so a long press only ever releases one instruction.
            ST_PAUSE_A: begin
                if (cont) begin
                    next_state_s = ST_PAUSE_B;
                end else begin
                    next_state_s = ST_PAUSE_A;
                end
            end
            ST_PAUSE_B: begin
                if (cont) begin
                    next_state_s = ST_PAUSE_B;
                end else begin
                    next_state_s = ST_FETCH1;
                end
            end
            default: next_state_s = ST_HALTED;
        endcase
    end

    // Output decode from the state register only.
    always_comb begin
        ld_pc       = 1'b0;
        ld_ir       = 1'b0;
        ld_mar      = 1'b0;
        ld_mdr      = 1'b0;
        gate_pc     = 1'b0;
        gate_mdr    = 1'b0;
        gate_alu    = 1'b0;
        gate_marmux = 1'b0;
        mio_en      = 1'b0;
        mem_oe_n    = 1'b1;
        mem_we_n    = 1'b1;
        halted      = 1'b0;
        paused      = 1'b0;
        case (state_r)
            ST_HALTED: halted = 1'b1;
            ST_FETCH1: begin
                gate_pc = 1'b1;
                ld_mar  = 1'b1;
                ld_pc   = 1'b1;
            end
            ST_FETCH2: begin
                mem_oe_n = 1'b0;
                mio_en   = 1'b1;
            end
            ST_FETCH3: begin
                mem_oe_n = 1'b0;
                mio_en   = 1'b1;
                ld_mdr   = 1'b1;
            end
            ST_FETCH4: begin
                gate_mdr = 1'b1;
                ld_ir    = 1'b1;
            end
            ST_DECODE:  halted = 1'b0;
            ST_PAUSE_A: paused = 1'b1;
            ST_PAUSE_B: paused = 1'b1;
            default:    halted = 1'b1;
        endcase
    end

endmodule
